fb_scanout: RTL and testbench

Parametrised framebuffer scanout engine. It sits between the LCD timing generator and the video buffer RAM. It turns live pixel coordinates into buffer read addresses with integer up-scaling, double-buffered base addresses and a multiplier-free row stride. It then expands the returned pixel word to 24-bit colour and re-aligns DE/HSYNC/VSYNC to the RAM and conversion latency.

---
 rtl/fb_scanout.sv | 188 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout engine between the LCD timing generator
// and the video buffer RAM.
//
// Turns live pixel coordinates into buffer read addresses. It up-scales by
// 2^SCALE_SHIFT in both axes and latches the base address and pixel mode
// once per frame on the VSYNC rising edge, which gives double buffering.
// The row stride is kept as a running sum, so no multiplier is needed.
// The returned 16-bit word is expanded to 24-bit colour, and DE/HSYNC/VSYNC
// are delayed so they line up with the colour.
//
// Ports:
//   clk, rst_              pixel clock, asynchronous active-low reset
//   iEN                    scanout enable (gates reads and colour only)
//   iMODE, iBASE           pixel format / frame base, sampled at VSYNC rise
//   iHADDR, iVADDR         live pixel column / row (row unused for addressing)
//   iDE, iHSYNC, iVSYNC    timing generator controls
//   oRAM_ADDR, oRAM_RD     buffer read address and strobe (1 cycle latency)
//   iRAM_DATA              buffer read data, RAM_LAT cycles after the address
//   oCOLOR                 {R,G,B} output, 2+RAM_LAT cycles after the input
//   oDE, oHSYNC, oVSYNC    controls realigned with oCOLOR
//   oFRAME_START           one-cycle pulse when the frame configuration latches
module fb_scanout #(
    parameter int H_W         = 10,
    parameter int V_W         = 9,
    parameter int FB_W        = 400,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int RAM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              iEN,
    input  logic [1:0]        iMODE,
    input  logic [ADDR_W-1:0] iBASE,
    input  logic [H_W-1:0]    iHADDR,
    input  logic [V_W-1:0]    iVADDR,
    input  logic              iDE,
    input  logic              iHSYNC,
    input  logic              iVSYNC,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic              oRAM_RD,
    input  logic [15:0]       iRAM_DATA,
    output logic [23:0]       oCOLOR,
    output logic              oDE,
    output logic              oHSYNC,
    output logic              oVSYNC,
    output logic              oFRAME_START
);

    localparam int              DEPTH     = 1 + RAM_LAT;
    localparam logic [1:0]      PHASE_MAX = 2'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(FB_W);

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [2:0] bar;
    } ctl_t;

    // Pixel-format expansion. Mode 10 is reserved and decodes like RGB565.
    // RGB565 replicates the top bits of each channel into its vacated LSBs,
    // so full scale maps to FF and zero maps to 00.
    function automatic logic [23:0] expand_pixel(input logic [1:0]  mode,
                                                 input logic [15:0] d,
                                                 input logic [2:0]  bar);
        logic [23:0] res;
        case (mode)
            2'b01:   res = {3{d[7:0]}};
            2'b11:   res = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            default: res = {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
        endcase
        return res;
    endfunction

    logic                vs_prev_q, vs_prev_d;
    logic                de_prev_q, de_prev_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [1:0]          line_phase_q, line_phase_d;
    logic                frame_start_q, frame_start_d;
    logic [ADDR_W-1:0]   ram_addr_p0_q, ram_addr_p0_d;
    logic                vld_p0_q, vld_p0_d;
    ctl_t                dly_q [DEPTH];
    ctl_t                dly_d [DEPTH];
    ctl_t                tail;
    logic [23:0]         color_p1_q, color_p1_d;
    logic                de_p1_q, de_p1_d;
    logic                hs_p1_q, hs_p1_d;
    logic                vs_p1_q, vs_p1_d;
    logic                vs_rise, de_fall;

    // Rows are tracked from DE edges, not from the row coordinate.
    logic unused_vaddr;
    assign unused_vaddr = ^iVADDR;

    always_comb begin
        vs_rise       = iVSYNC & ~vs_prev_q;
        de_fall       = de_prev_q & ~iDE;
        vs_prev_d     = iVSYNC;
        de_prev_d     = iDE;
        mode_d        = mode_q;
        row_base_d    = row_base_q;
        line_phase_d  = line_phase_q;
        frame_start_d = vs_rise;

        // A VSYNC load takes priority and swallows a coincident row step.
        if (vs_rise) begin
            mode_d       = iMODE;
            row_base_d   = iBASE;
            line_phase_d = 2'd0;
        end else if (de_fall) begin
            if (line_phase_q == PHASE_MAX) begin
                line_phase_d = 2'd0;
                row_base_d   = row_base_q + STRIDE;
            end else begin
                line_phase_d = line_phase_q + 2'd1;
            end
        end

        // Stage 0: address generation; address holds while idle
        vld_p0_d      = iDE & iEN;
        ram_addr_p0_d = ram_addr_p0_q;
        if (vld_p0_d) begin
            ram_addr_p0_d = row_base_q + ADDR_W'(iHADDR >> SCALE_SHIFT);
        end

        dly_d[0] = '{de: iDE, hs: iHSYNC, vs: iVSYNC, bar: iHADDR[H_W-1 -: 3]};
        for (int i = 1; i < DEPTH; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        tail = dly_q[DEPTH-1];

        // Stage 1: colour conversion aligned with returned RAM data
        color_p1_d = '0;
        if (tail.de && iEN) begin
            color_p1_d = expand_pixel(mode_q, iRAM_DATA, tail.bar);
        end
        de_p1_d = tail.de;
        hs_p1_d = tail.hs;
        vs_p1_d = tail.vs;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            vs_prev_q     <= 1'b0;
            de_prev_q     <= 1'b0;
            mode_q        <= 2'b00;
            row_base_q    <= '0;
            line_phase_q  <= 2'd0;
            frame_start_q <= 1'b0;
            ram_addr_p0_q <= '0;
            vld_p0_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= '0;
            end
            color_p1_q    <= '0;
            de_p1_q       <= 1'b0;
            hs_p1_q       <= 1'b0;
            vs_p1_q       <= 1'b0;
        end else begin
            vs_prev_q     <= vs_prev_d;
            de_prev_q     <= de_prev_d;
            mode_q        <= mode_d;
            row_base_q    <= row_base_d;
            line_phase_q  <= line_phase_d;
            frame_start_q <= frame_start_d;
            ram_addr_p0_q <= ram_addr_p0_d;
            vld_p0_q      <= vld_p0_d;
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= dly_d[i];
            end
            color_p1_q    <= color_p1_d;
            de_p1_q       <= de_p1_d;
            hs_p1_q       <= hs_p1_d;
            vs_p1_q       <= vs_p1_d;
        end
    end

    assign oRAM_ADDR    = ram_addr_p0_q;
    assign oRAM_RD      = vld_p0_q;
    assign oCOLOR       = color_p1_q;
    assign oDE          = de_p1_q;
    assign oHSYNC       = hs_p1_q;
    assign oVSYNC       = vs_p1_q;
    assign oFRAME_START = frame_start_q;

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        iEN = 1'b1;
    logic [1:0]  iMODE = 2'b00;
    logic [16:0] iBASE = '0;
    logic [9:0]  iHADDR = '0;
    logic [8:0]  iVADDR = '0;
    logic        iDE = 1'b0, iHSYNC = 1'b0, iVSYNC = 1'b0;
    logic [16:0] oRAM_ADDR;
    logic        oRAM_RD;
    logic [15:0] ram_data = '0;
    logic [23:0] oCOLOR;
    logic        oDE, oHSYNC, oVSYNC, oFRAME_START;

    logic [15:0] zero16 = '0;
    logic [16:0] l2_addr, l3_addr, s0_addr;
    logic        l2_rd, l3_rd, s0_rd, l2_de, l3_de, s0_de;
    logic [23:0] l2_col, l3_col, s0_col;
    logic        l2_hs, l2_vs, l2_fs, l3_hs, l3_vs, l3_fs, s0_hs, s0_vs, s0_fs;

    always #5 clk = ~clk;

    fb_scanout dut (
        .clk(clk), .rst_(rst_), .iEN(iEN), .iMODE(iMODE), .iBASE(iBASE),
        .iHADDR(iHADDR), .iVADDR(iVADDR), .iDE(iDE), .iHSYNC(iHSYNC), .iVSYNC(iVSYNC),
        .oRAM_ADDR(oRAM_ADDR), .oRAM_RD(oRAM_RD), .iRAM_DATA(ram_data), .oCOLOR(oCOLOR),
        .oDE(oDE), .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oFRAME_START(oFRAME_START));

    fb_scanout #(.RAM_LAT(2)) dut_l2 (
        .clk(clk), .rst_(rst_), .iEN(iEN), .iMODE(iMODE), .iBASE(iBASE),
        .iHADDR(iHADDR), .iVADDR(iVADDR), .iDE(iDE), .iHSYNC(iHSYNC), .iVSYNC(iVSYNC),
        .oRAM_ADDR(l2_addr), .oRAM_RD(l2_rd), .iRAM_DATA(zero16), .oCOLOR(l2_col),
        .oDE(l2_de), .oHSYNC(l2_hs), .oVSYNC(l2_vs), .oFRAME_START(l2_fs));

    fb_scanout #(.RAM_LAT(3)) dut_l3 (
        .clk(clk), .rst_(rst_), .iEN(iEN), .iMODE(iMODE), .iBASE(iBASE),
        .iHADDR(iHADDR), .iVADDR(iVADDR), .iDE(iDE), .iHSYNC(iHSYNC), .iVSYNC(iVSYNC),
        .oRAM_ADDR(l3_addr), .oRAM_RD(l3_rd), .iRAM_DATA(zero16), .oCOLOR(l3_col),
        .oDE(l3_de), .oHSYNC(l3_hs), .oVSYNC(l3_vs), .oFRAME_START(l3_fs));

    fb_scanout #(.SCALE_SHIFT(0), .FB_W(800)) dut_s0 (
        .clk(clk), .rst_(rst_), .iEN(iEN), .iMODE(iMODE), .iBASE(iBASE),
        .iHADDR(iHADDR), .iVADDR(iVADDR), .iDE(iDE), .iHSYNC(iHSYNC), .iVSYNC(iVSYNC),
        .oRAM_ADDR(s0_addr), .oRAM_RD(s0_rd), .iRAM_DATA(zero16), .oCOLOR(s0_col),
        .oDE(s0_de), .oHSYNC(s0_hs), .oVSYNC(s0_vs), .oFRAME_START(s0_fs));

    // Buffer RAM model with one cycle of read latency
    logic [15:0] mem [0:1023];
    always @(posedge clk) ram_data <= mem[oRAM_ADDR[9:0]];

    int          n_checks = 0;
    int          n_fail = 0;
    int          fs_cnt = 0;
    int          hs_cnt = 0;
    logic [16:0] exp_addr_q [$];
    logic [23:0] exp_col_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read or a pixel
    always @(negedge clk) begin
        if (rst_) begin
            if (oRAM_RD) begin
                if (exp_addr_q.size() == 0) chk("unexpected_ram_rd", 32'(oRAM_ADDR), 32'hFFFF_FFFF);
                else chk("ram_addr", 32'(oRAM_ADDR), 32'(exp_addr_q.pop_front()));
            end
            if (oDE) begin
                if (exp_col_q.size() == 0) chk("unexpected_de", 32'(oCOLOR), 32'hFFFF_FFFF);
                else chk("color", 32'(oCOLOR), 32'(exp_col_q.pop_front()));
            end
            if (oFRAME_START) fs_cnt++;
            if (oHSYNC) hs_cnt++;
        end
    end

    task automatic pix(input int h, input logic [16:0] ea, input logic push_a, input logic [23:0] ec);
        iHADDR = 10'(h);
        iDE    = 1'b1;
        if (push_a) exp_addr_q.push_back(ea);
        exp_col_q.push_back(ec);
        @(negedge clk);
    endtask

    task automatic blank(input int n);
        iDE = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync(input logic [16:0] b, input logic [1:0] m);
        iBASE  = b;
        iMODE  = m;
        iVSYNC = 1'b1;
        repeat (2) @(negedge clk);
        iVSYNC = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int fs0, hs0, h0, k_rd, k_de, k_l2, k_l3;
        logic [16:0] rb;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_addr", 32'(oRAM_ADDR), 0);
        chk("reset_color", 32'(oCOLOR), 0);
        chk("reset_ctl", {27'd0, oRAM_RD, oDE, oHSYNC, oVSYNC, oFRAME_START}, 0);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame of short lines, scaled addressing, base change at line 100
        fs0 = fs_cnt;
        vsync(17'h0, 2'b00);
        chk("frame_start_once", fs_cnt - fs0, 1);
        for (int line = 0; line < 480; line++) begin
            if (line == 100) iBASE = 17'h10000;
            rb = 17'((line >> 1) * 400);
            h0 = (line == 479) ? 796 : 0;
            for (int i = 0; i < 4; i++) begin
                pix(h0 + i, rb + 17'((h0 + i) >> 1), 1'b1, 24'h0);
                if (line == 1 && i == 0) chk("s0_line1_start", 32'(s0_addr), 800);
                if (line == 2 && i == 0) chk("s0_line2_start", 32'(s0_addr), 1600);
                if (line == 2 && i == 0) chk("line2_start", 32'(oRAM_ADDR), 400);
            end
            if (line == 479) chk("line479_end", 32'(oRAM_ADDR), 95999);
            blank(3);
        end

        // Double buffer switch
        fs0 = fs_cnt;
        vsync(17'h10000, 2'b00);
        chk("frame_start_switch", fs_cnt - fs0, 1);
        for (int i = 0; i < 4; i++) pix(i, 17'h10000 + 17'(i >> 1), 1'b1, 24'h0);
        blank(4);

        // Address wrap
        vsync(17'h1FFFF, 2'b00);
        pix(0, 17'h1FFFF, 1'b1, 24'h0);
        pix(1, 17'h1FFFF, 1'b1, 24'h0);
        pix(2, 17'h00000, 1'b1, 24'h0);
        pix(3, 17'h00000, 1'b1, 24'h0);
        blank(4);

        // RGB565 expansion
        mem[0] = 16'hF800; mem[1] = 16'h07E0; mem[2] = 16'h001F; mem[3] = 16'h8410;
        vsync(17'h0, 2'b00);
        pix(0, 17'd0, 1'b1, 24'hFF0000);
        pix(2, 17'd1, 1'b1, 24'h00FF00);
        pix(4, 17'd2, 1'b1, 24'h0000FF);
        pix(6, 17'd3, 1'b1, 24'h848284);
        blank(4);

        // GRAY8
        mem[0] = 16'h0037;
        vsync(17'h0, 2'b01);
        pix(0, 17'd0, 1'b1, 24'h373737);
        blank(4);
        for (int i = 0; i < 4; i++) mem[i] = '0;

        // Colour-bar pattern, then a mid-frame mode change that must be ignored
        vsync(17'h0, 2'b11);
        pix(0, 17'd0, 1'b1, 24'h000000);
        pix(128, 17'd64, 1'b1, 24'h0000FF);
        pix(256, 17'd128, 1'b1, 24'h00FF00);
        pix(768, 17'd384, 1'b1, 24'hFFFF00);
        blank(3);
        iMODE = 2'b00;
        pix(128, 17'd64, 1'b1, 24'h0000FF);
        blank(4);

        // Latency of a single-cycle DE pulse, across RAM_LAT 1..3
        vsync(17'h0, 2'b00);
        k_rd = 0; k_de = 0; k_l2 = 0; k_l3 = 0;
        iHADDR = '0;
        iDE = 1'b1;
        exp_addr_q.push_back(17'd0);
        exp_col_q.push_back(24'h0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            iDE = 1'b0;
            if (oRAM_RD && k_rd == 0) k_rd = k;
            if (oDE && k_de == 0) k_de = k;
            if (l2_de && k_l2 == 0) k_l2 = k;
            if (l3_de && k_l3 == 0) k_l3 = k;
        end
        chk("lat_ram_rd", k_rd, 1);
        chk("lat_de_lat1", k_de, 3);
        chk("lat_de_lat2", k_l2, 4);
        chk("lat_de_lat3", k_l3, 5);

        // Enable low: no reads, colour zero, syncs still pass
        iEN = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) pix(i, 17'd0, 1'b0, 24'h0);
        blank(2);
        iHSYNC = 1'b1;
        repeat (2) @(negedge clk);
        iHSYNC = 1'b0;
        repeat (5) @(negedge clk);
        chk("hsync_passes_en0", hs_cnt - hs0, 2);
        iEN = 1'b1;

        // Asynchronous reset mid-line
        vsync(17'h0, 2'b00);
        pix(0, 17'd0, 1'b1, 24'h0);
        pix(1, 17'd0, 1'b1, 24'h0);
        #2 rst_ = 1'b0;
        #1;
        chk("async_reset_addr", 32'(oRAM_ADDR), 0);
        chk("async_reset_color", 32'(oCOLOR), 0);
        chk("async_reset_ctl", {27'd0, oRAM_RD, oDE, oHSYNC, oVSYNC, oFRAME_START}, 0);
        exp_addr_q.delete();
        exp_col_q.delete();
        iDE = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (6) @(negedge clk);
        vsync(17'h00123, 2'b00);
        pix(0, 17'h00123, 1'b1, 24'h0);
        chk("post_reset_first_addr", 32'(oRAM_ADDR), 32'h123);
        blank(6);

        chk("addr_queue_drained", exp_addr_q.size(), 0);
        chk("color_queue_drained", exp_col_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
